// File: rtl/modulo_decodificador.sv
// Receive-side 4b code-word decoder: inverts the line code, pairs nibbles into
// bytes and delivers them through a one-entry valid/ready output register.
module modulo_decodificador #(
   parameter bit HI_FIRST = 1'b1,
   parameter int COUNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s0,
   input  logic               s1,
   input  logic               s2,
   input  logic               s3,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               sync,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] byte_count
);

   // Handshakes: a word moves on an edge where valid & ready are both high;
   // in_ready never depends on in_valid, and out_valid never depends on out_ready.
   typedef enum logic {S_FIRST, S_SECOND} state_t;

   state_t     state, state_nxt;
   logic [3:0] code, nib, pending, pending_nxt;
   logic       accept, deliver, load;

   assign code    = {s3, s2, s1, s0};
   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   always_comb begin
      nib = 4'h0;
      case (code)
         4'h0: nib = 4'h3;
         4'h1: nib = 4'hD;
         4'h2: nib = 4'h6;
         4'h3: nib = 4'h1;
         4'h4: nib = 4'hB;
         4'h5: nib = 4'hF;
         4'h6: nib = 4'hE;
         4'h7: nib = 4'hC;
         4'h8: nib = 4'h4;
         4'h9: nib = 4'h2;
         4'hA: nib = 4'h0;
         4'hB: nib = 4'hA;
         4'hC: nib = 4'h9;
         4'hD: nib = 4'h7;
         4'hE: nib = 4'h8;
         4'hF: nib = 4'h5;
         default: nib = 4'h0;
      endcase
   end

   // Only the second nibble needs room in the output register.
   assign in_ready = (state == S_FIRST) ? 1'b1 : (!out_valid | out_ready);

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      load        = 1'b0;
      if (accept) begin
         // sync on an accepting cycle restarts the pair with this word.
         if ((state == S_SECOND) && !sync) begin
            load      = 1'b1;
            state_nxt = S_FIRST;
         end else begin
            pending_nxt = nib;
            state_nxt   = S_SECOND;
         end
      end else if (sync) begin
         state_nxt = S_FIRST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FIRST;
         pending <= 4'h0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= 8'h00;
         out_valid  <= 1'b0;
         byte_count <= '0;
      end else begin
         if (load) begin
            out_data <= HI_FIRST ? {pending, nib} : {nib, pending};
         end
         out_valid <= load | (out_valid & !out_ready);
         if (deliver) begin
            byte_count <= byte_count + COUNT_W'(1);
         end
      end
   end

endmodule

// File: doc/modulo_decodificador.md
Name: modulo_decodificador

Overview:
- Receive-side counterpart of the 4-bit line encoder. Accepts a stream of 4-bit code words over a valid/ready handshake and maps each back to its 4-bit data nibble with the inverse code table.
- Pairs consecutive nibbles into bytes and delivers them through a one-entry output register with its own valid/ready handshake.
- Sits between the channel/deserialiser and the byte consumer.

Parameters:
- HI_FIRST, 1, 1 = first nibble of a pair is data[7:4]; 0 = first nibble is data[3:0].
- COUNT_W, 8, width of the delivered-byte counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s0  input  1  code bit 0 (LSB).
- s1  input  1  code bit 1.
- s2  input  1  code bit 2.
- s3  input  1  code bit 3 (MSB); the code word is {s3,s2,s1,s0}.
- in_valid  input  1  code word present on s3..s0.
- in_ready  output  1  block accepts a code word this cycle.
- sync  input  1  frame-align pulse; discards any pending first nibble.
- out_data  output  8  decoded byte.
- out_valid  output  1  out_data holds an undelivered byte.
- out_ready  input  1  consumer accepts out_data.
- byte_count  output  COUNT_W  number of bytes delivered, wraps.

Behaviour:
- Decode table, code to nibble (hex): 0→3, 1→D, 2→6, 3→1, 4→B, 5→F, 6→E, 7→C, 8→4, 9→2, A→0, B→A, C→9, D→7, E→8, F→5.
  - Nibble bits are {bit0,bit1,bit2,bit3}, with bit0 as MSB.
  - The table is a bijection. Every code is legal, so there is no error output.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output delivery = out_valid & out_ready.
  - in_ready is combinational:
    - S_FIRST: in_ready = 1.
    - S_SECOND: in_ready = !out_valid | out_ready.
- State machine:
  - S_FIRST: on accept, store the decoded nibble in the pending register, then go to S_SECOND.
  - S_SECOND: on accept, load out_data = {pending, decoded} (HI_FIRST=1) or {decoded, pending} (HI_FIRST=0), set out_valid, then go to S_FIRST.
- Latency: out_valid rises on the clock edge that accepts the second nibble, i.e. the byte is visible the cycle after that accept.
- Output register:
  - out_data stays stable while out_valid=1 and out_ready=0.
  - Delivery without a new load clears out_valid on the next edge.
  - Delivery and a new load in the same cycle keep out_valid=1 with the new byte, so back-to-back bytes pass at full rate.
- byte_count:
  - Increments by 1 on each delivery.
  - Wraps from 2^COUNT_W-1 to 0.
  - Does not count bytes that are loaded but not yet delivered.
- sync:
  - In S_SECOND: forces S_FIRST and discards the pending nibble.
  - sync together with an accept in the same cycle: the accepted word is treated as the first nibble of a new pair, and the state ends in S_SECOND.
  - sync has no effect on out_data, out_valid or byte_count.
- Reset:
  - rst_n low asynchronously forces state S_FIRST, pending=0, out_data=8'h00, out_valid=0, byte_count=0; in_ready then reads 1.
  - A byte held but not yet delivered is lost on reset.
  - Release is synchronous to clk, and the first accept is allowed on the first edge after release.
- in_valid low: state and pending register hold.
- s3..s0 are ignored when there is no accept.

Test Plan:
- Basic decode: reset, out_ready=1, send codes A then 3 → out_data=8'h01, out_valid for 1 cycle, byte_count=1; codes 5,5 → 8'hFF, byte_count=2.
- Full table: encode every nibble 0..F with the team encoder, pair it with nibble 0, stream continuously → 16 bytes n0 in order, one byte every 2 cycles, no bubbles; with HI_FIRST=0 → 0n.
- Backpressure:
  - Hold out_ready=0 and send codes 3,9 → 8'h12 held stable.
  - Send code 8 → accepted (nibble 4); then in_ready=0 in S_SECOND.
  - Raise out_ready → 8'h12 delivered; the next code A is accepted the same cycle → next byte 8'h40.
- sync: send code 3, pulse sync alone, then send codes 9,8 → 8'h24 (the nibble 1 is discarded).
  - Repeat with sync asserted on the same cycle as code 9 → 8'h24.
- Counter wrap: deliver 256 bytes → byte_count returns to 0 and continues at 1 on the 257th.
- Reset mid-operation: assert rst_n low while out_valid=1 in S_SECOND → out_valid=0, out_data=0, byte_count=0 immediately, without a clock edge. After release, codes A,A → 8'h00.
